instr_fetch_ctrl: RTL

- Sequences the word-addressed instruction memory (9-bit address, combinational 32-bit read data) on behalf of the decode stage.
- Owns the program counter and a small FIFO of fetched instruction/PC pairs. Presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects with queue flush, and stops fetching on the HALT word.
- Sits between the instruction memory and decode in the processor top.

---
 rtl/instr_fetch_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the instruction
// memory address, and buffers fetched {instruction, PC} pairs in a small
// queue that is presented to decode over a valid/ready handshake.
// Branch/jump redirects flush the queue and restart fetch at the new PC.
// Fetching stops after the HALT word has been enqueued.
// Optional build macro FETCH_PERF_EN adds fetch/stall performance counters.
module instr_fetch_ctrl #(
    parameter int          DEPTH     = 2,
    parameter logic [8:0]  RESET_PC  = 9'd0,
    parameter logic [31:0] HALT_WORD = 32'h0000001F
) (
    input  logic        clk,
    input  logic        rst,
    output logic [8:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [8:0]  out_pc,
    input  logic        redirect,
    input  logic [8:0]  redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    // Queue storage: each entry is {instruction, fetch PC}
    logic [40:0]   mem_q [DEPTH];

    state_t        state_q, state_d;
    logic [8:0]    pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_instr_q;
    logic [8:0]    out_pc_q;
    logic [40:0]   head_d;
    logic          pop;
    logic          fetch;

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;

    // Handshake, fetch decision and next-state computation
    always_comb begin
        pop         = out_valid_q && out_ready;
        fetch       = (state_q == ST_RUN) && !redirect && ((count_q != FULL_CNT) || pop);
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halted_d    = halted_q;
        if (redirect) begin
            // A pop this cycle still completes; the flush discards the rest
            state_d  = ST_RUN;
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (fetch) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_d     = pc_q + 9'd1;
                if (imem_data == HALT_WORD) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (fetch && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !fetch) begin
                count_d = count_q - CW'(1);
            end
        end
        out_valid_d = (count_d != '0);
        // The new word becomes head directly when it lands in the head slot
        if (fetch && (wr_ptr_q == rd_ptr_d)) begin
            head_d = {imem_data, pc_q};
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Queue storage write; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (fetch) begin
            mem_q[wr_ptr_q] <= {imem_data, pc_q};
        end
    end

    // FSM, pointers, PC and registered head outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                out_instr_q <= head_d[40:9];
                out_pc_q    <= head_d[8:0];
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;

    // Count fetches and queue-full stalls; redirects do not clear them
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (fetch) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if ((state_q == ST_RUN) && !fetch && !redirect) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule
